conv_frame_scheduler: RTL and testbench
=======================================

// Module: conv_frame_scheduler
// PURPOSE
//  Sequences convolution_top_module over multi-frame workloads. Pulls pixels and 5x5 kernel weights from two
//  valid/ready sources and drives the datapath's iValid/iWren/iADDR/iX/iW strobes: one frame of IMG_W*IMG_H
//  pixels, with the K*K weights written alongside the first K*K pixels. Counts datapath results and signals
//  completion. Sits between the DMA/stream front-end and the convolution datapath.
// PARAMETERS
//  IMG_W     32  pixels per row
//  IMG_H     32  rows per frame
//  K         5   kernel side; K*K weights per frame
//  DW        8   signed pixel/weight width
//  AW        5   weight address width, >= clog2(K*K)
//  DRAIN_CYC 5   cycles after the last pixel before oDone
// PORTS
//  iCLK        in   1   clock
//  iRSTn       in   1   async active-low reset
//  iStart      in   1   start pulse; sampled only in IDLE
//  iNumFrames  in   8   frames per job; sampled with iStart
//  iXValid     in   1   pixel source valid
//  iXData      in   DW  pixel, signed
//  oXReady     out  1   pixel accepted when iXValid&oXReady
//  iWValid     in   1   weight source valid
//  iWData      in   DW  weight, signed
//  oWReady     out  1   weight accepted when iWValid&oWReady
//  oConvValid  out  1   -> datapath iValid
//  oConvWren   out  1   -> datapath iWren
//  oConvAddr   out  AW  -> datapath iADDR
//  oConvX      out  DW  -> datapath iX
//  oConvW      out  DW  -> datapath iW
//  iConvYValid in   1   <- datapath oValid
//  oYCount     out  20  results counted this job; saturates at all-ones
//  oFrameIdx   out  8   frame currently streaming
//  oBusy       out  1   high in any state except IDLE
//  oDone       out  1   1-cycle pulse at job end
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, counters 0. Reset mid-job aborts immediately; there is no resume.
//  FSM states and transitions:
//    IDLE   -> STREAM on iStart with iNumFrames!=0; -> DONE on iStart with iNumFrames==0.
//    STREAM -> next frame when the last pixel of a non-final frame is accepted; -> DRAIN when the last pixel
//              of the final frame is accepted.
//    DRAIN  -> DONE after DRAIN_CYC cycles.
//    DONE   -> IDLE after one cycle; oDone=1 during DONE.
//  Pixel counter p runs 0..IMG_W*IMG_H-1. needW = (p < K*K) in every frame.
//  oXReady = STREAM & (!needW | iWValid). oWReady = STREAM & needW & iXValid.
//    The pixel and its weight are accepted in the same cycle. No ready depends on its own valid.
//  Accept cycle t -> outputs at t+1, all registered:
//    oConvValid=1; oConvX=pixel; oConvWren=needW; oConvAddr=needW ? p : 0; oConvW=needW ? weight : 0.
//  No accept -> bubble: oConvValid=0, oConvWren=0, oConvAddr/X/W=0; p holds.
//  p wraps to 0 and oFrameIdx increments on the last pixel of each frame.
//  oYCount clears on an accepted iStart. It increments on iConvYValid in STREAM and DRAIN. Results arriving
//    after DRAIN are dropped.
//  iStart outside IDLE is ignored. Weights and pixels presented outside STREAM are not accepted.
// CONFIGURATION
//  CONV_SCHED_WREUSE_EN defined: needW=(p<K*K)&(oFrameIdx==0). Weights load once; later frames reuse datapath
//    weight memory, and oWReady stays 0 after frame 0.
//  Undefined: weights reload every frame (K*K*iNumFrames weight accepts per job).
// STRUCTURE
//  Shared package conv_pkg: IMG_W, IMG_H, K, DW, AW and the FSM state encodings, shared with the datapath.
//  One sub-module, conv_pix_frame_cnt: pixel/frame counter with wrap and last-pixel/last-frame flags.
// TESTING
//  1 Reset: assert iRSTn=0 mid-STREAM -> all outputs 0 in the same cycle; next iStart restarts at frame 0, p=0.
//  2 One frame, both sources always valid, weights 1..25 -> 1024 consecutive oConvValid.
//    First 25 cycles: oConvWren=1, addr 0..24, oConvW 1..25. Then oConvW=0. oDone occurs 1+DRAIN_CYC+1 cycles
//    after the last accept.
//  3 iNumFrames=6 -> 6144 oConvValid; oFrameIdx steps 0..5. Without the macro: 150 weight accepts, addr
//    restarts at 0 each frame. With the macro: exactly 25.
//  4 Drop iWValid for 3 cycles at p=10 -> oConvValid=0 for 3 cycles, no pixel consumed, addr resumes at 10.
//    Drop iXValid at p=500 -> bubble, and oWReady stays 0.
//  5 iNumFrames=0 -> oDone 1 cycle after iStart, no oConvValid. iStart pulsed during STREAM -> no effect.
//  6 Datapath model giving 784 iConvYValid per frame, 3 frames -> oYCount=2352 at oDone.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : conv_pkg                                                    |
// | Purpose  : Geometry constants and FSM state encoding shared by the     |
// |            convolution frame scheduler and the convolution datapath.   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package conv_pkg;

  localparam int IMG_W     = 32;  // pixels per row
  localparam int IMG_H     = 32;  // rows per frame
  localparam int K         = 5;   // kernel side
  localparam int DW        = 8;   // signed pixel / weight width
  localparam int AW        = 5;   // weight address width
  localparam int DRAIN_CYC = 5;   // cycles after the last pixel before done
  localparam int FRAME_W   = 8;   // frame index / frame count width
  localparam int YCNT_W    = 20;  // result counter width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_e;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_pix_frame_cnt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : conv_pix_frame_cnt                                          |
// | Purpose  : Pixel-in-frame and frame-in-job counter with wrap, plus     |
// |            last-pixel / last-frame flags for the scheduler FSM.        |
// | Ports    : iCLK, iRSTn      clock, async active-low reset              |
// |            iClear           restart at pixel 0, frame 0 (job start)    |
// |            iAdvance         one pixel accepted this cycle              |
// |            iNumFrames       frames in the current job                  |
// |            oPix / oFrame    current pixel and frame index              |
// |            oLastPix         current pixel is the last of its frame     |
// |            oLastFrame       current frame is the last of the job       |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module conv_pix_frame_cnt #(
  parameter int PIX_PER_FRAME = 1024,
  parameter int PIX_W         = 10,
  parameter int FRAME_W       = 8
) (
  input  logic               iCLK,
  input  logic               iRSTn,
  input  logic               iClear,
  input  logic               iAdvance,
  input  logic [FRAME_W-1:0] iNumFrames,
  output logic [PIX_W-1:0]   oPix,
  output logic [FRAME_W-1:0] oFrame,
  output logic               oLastPix,
  output logic               oLastFrame
);

  localparam logic [PIX_W-1:0] C_PIX_LAST = PIX_W'(PIX_PER_FRAME - 1);

  logic [PIX_W-1:0]   pix_q,   pix_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  assign oPix       = pix_q;
  assign oFrame     = frame_q;
  assign oLastPix   = (pix_q == C_PIX_LAST);
  assign oLastFrame = (frame_q == (iNumFrames - {{(FRAME_W-1){1'b0}}, 1'b1}));

  always_comb begin
    pix_d   = pix_q;
    frame_d = frame_q;
    if (iClear) begin
      pix_d   = '0;
      frame_d = '0;
    end else if (iAdvance) begin
      if (oLastPix) begin
        pix_d   = '0;
        frame_d = frame_q + {{(FRAME_W-1){1'b0}}, 1'b1};
      end else begin
        pix_d   = pix_q + {{(PIX_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      pix_q   <= '0;
      frame_q <= '0;
    end else begin
      pix_q   <= pix_d;
      frame_q <= frame_d;
    end
  end

endmodule : conv_pix_frame_cnt
`default_nettype wire

// File: rtl/conv_frame_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : conv_frame_scheduler                                        |
// | Purpose  : Sequences the convolution datapath over multi-frame jobs.   |
// |            Pulls pixels and kernel weights from two valid/ready        |
// |            sources, drives registered datapath strobes, counts         |
// |            datapath results and pulses oDone at job end.               |
// | Ports    : iCLK/iRSTn               clock, async active-low reset      |
// |            iStart/iNumFrames        job start and frame count          |
// |            iXValid/iXData/oXReady   pixel stream                       |
// |            iWValid/iWData/oWReady   weight stream                      |
// |            oConv*                   datapath iValid/iWren/iADDR/iX/iW  |
// |            iConvYValid              datapath result strobe             |
// |            oYCount/oFrameIdx        result count, current frame        |
// |            oBusy/oDone              status                             |
// | Config   : CONV_SCHED_WREUSE_EN - load weights in frame 0 only; later  |
// |            frames reuse the datapath weight memory.                    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module conv_frame_scheduler #(
  parameter int IMG_W     = conv_pkg::IMG_W,
  parameter int IMG_H     = conv_pkg::IMG_H,
  parameter int K         = conv_pkg::K,
  parameter int DW        = conv_pkg::DW,
  parameter int AW        = conv_pkg::AW,
  parameter int DRAIN_CYC = conv_pkg::DRAIN_CYC
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iStart,
  input  logic [7:0]    iNumFrames,
  input  logic          iXValid,
  input  logic [DW-1:0] iXData,
  output logic          oXReady,
  input  logic          iWValid,
  input  logic [DW-1:0] iWData,
  output logic          oWReady,
  output logic          oConvValid,
  output logic          oConvWren,
  output logic [AW-1:0] oConvAddr,
  output logic [DW-1:0] oConvX,
  output logic [DW-1:0] oConvW,
  input  logic          iConvYValid,
  output logic [19:0]   oYCount,
  output logic [7:0]    oFrameIdx,
  output logic          oBusy,
  output logic          oDone
);

  import conv_pkg::*;

  localparam int               PIX_PER_FRAME = IMG_W * IMG_H;
  localparam int               PIX_W         = $clog2(PIX_PER_FRAME);
  localparam int               DRAIN_W       = $clog2(DRAIN_CYC + 1);
  localparam logic [PIX_W-1:0] C_KK          = PIX_W'(K * K);
  localparam logic [19:0]      C_YMAX        = '1;

  sched_state_e         state_q, state_d;
  logic [7:0]           num_frames_q, num_frames_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [19:0]          y_count_q, y_count_d;
  logic                 conv_valid_q, conv_valid_d;
  logic                 conv_wren_q, conv_wren_d;
  logic [AW-1:0]        conv_addr_q, conv_addr_d;
  logic [DW-1:0]        conv_x_q, conv_x_d;
  logic [DW-1:0]        conv_w_q, conv_w_d;

  logic [PIX_W-1:0]     pix;
  logic [7:0]           frame;
  logic                 last_pix;
  logic                 last_frame;
  logic                 in_stream;
  logic                 need_w;
  logic                 accept;
  logic                 start_acc;

  assign in_stream = (state_q == ST_STREAM);
  assign start_acc = (state_q == ST_IDLE) && iStart;

`ifdef CONV_SCHED_WREUSE_EN
  assign need_w = (pix < C_KK) && (frame == 8'd0);
`else
  assign need_w = (pix < C_KK);
`endif

  // Readies look only at the other source's valid, so neither handshake
  // forms a combinational loop through its own valid.
  assign oXReady = in_stream && (!need_w || iWValid);
  assign oWReady = in_stream && need_w && iXValid;
  assign accept  = iXValid && oXReady;

  conv_pix_frame_cnt #(
    .PIX_PER_FRAME (PIX_PER_FRAME),
    .PIX_W         (PIX_W),
    .FRAME_W       (8)
  ) u_cnt (
    .iCLK       (iCLK),
    .iRSTn      (iRSTn),
    .iClear     (start_acc),
    .iAdvance   (accept),
    .iNumFrames (num_frames_q),
    .oPix       (pix),
    .oFrame     (frame),
    .oLastPix   (last_pix),
    .oLastFrame (last_frame)
  );

  always_comb begin
    state_d      = state_q;
    num_frames_d = num_frames_q;
    drain_cnt_d  = drain_cnt_q;
    y_count_d    = y_count_q;

    // Datapath strobes: registered copy of this cycle's accept, zero on bubble.
    conv_valid_d = accept;
    conv_wren_d  = accept && need_w;
    conv_addr_d  = (accept && need_w) ? AW'(pix) : '0;
    conv_x_d     = accept ? iXData : '0;
    conv_w_d     = (accept && need_w) ? iWData : '0;

    if (((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && iConvYValid &&
        (y_count_q != C_YMAX)) begin
      y_count_d = y_count_q + 20'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          num_frames_d = iNumFrames;
          y_count_d    = '0;
          state_d      = (iNumFrames != 8'd0) ? ST_STREAM : ST_DONE;
        end
      end
      ST_STREAM: begin
        if (accept && last_pix && last_frame) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // First DRAIN cycle carries the last pixel's strobes; DRAIN_CYC
        // further cycles follow before DONE.
        if (drain_cnt_q == DRAIN_W'(DRAIN_CYC)) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + {{(DRAIN_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q      <= ST_IDLE;
      num_frames_q <= '0;
      drain_cnt_q  <= '0;
      y_count_q    <= '0;
      conv_valid_q <= 1'b0;
      conv_wren_q  <= 1'b0;
      conv_addr_q  <= '0;
      conv_x_q     <= '0;
      conv_w_q     <= '0;
    end else begin
      state_q      <= state_d;
      num_frames_q <= num_frames_d;
      drain_cnt_q  <= drain_cnt_d;
      y_count_q    <= y_count_d;
      conv_valid_q <= conv_valid_d;
      conv_wren_q  <= conv_wren_d;
      conv_addr_q  <= conv_addr_d;
      conv_x_q     <= conv_x_d;
      conv_w_q     <= conv_w_d;
    end
  end

  assign oConvValid = conv_valid_q;
  assign oConvWren  = conv_wren_q;
  assign oConvAddr  = conv_addr_q;
  assign oConvX     = conv_x_q;
  assign oConvW     = conv_w_q;
  assign oYCount    = y_count_q;
  assign oFrameIdx  = frame;
  assign oBusy      = (state_q != ST_IDLE);
  assign oDone      = (state_q == ST_DONE);

endmodule : conv_frame_scheduler
`default_nettype wire

// File: tb/tb_conv_frame_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_conv_frame_scheduler                                     |
// | Purpose  : Self-checking bench for conv_frame_scheduler. Random        |
// |            source valids and data; an event-level model (accept count, |
// |            job start and done cycles) predicts every output each cycle.|
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_conv_frame_scheduler;

  localparam int PPF   = 1024;      // pixels per frame
  localparam int KK    = 25;        // weights per frame
  localparam int BIG   = 1 << 30;
  localparam int YSAT  = 1048575;

  logic       iCLK = 1'b0;
  logic       iRSTn = 1'b0;
  logic       iStart = 1'b0;
  logic [7:0] iNumFrames = 8'd0;
  logic       iXValid = 1'b0;
  logic [7:0] iXData = 8'd0;
  logic       iWValid = 1'b0;
  logic [7:0] iWData = 8'd0;
  logic       iConvYValid = 1'b0;
  logic       oXReady, oWReady, oConvValid, oConvWren, oBusy, oDone;
  logic [4:0] oConvAddr;
  logic [7:0] oConvX, oConvW, oFrameIdx;
  logic [19:0] oYCount;

  conv_frame_scheduler dut (
    .iCLK        (iCLK),
    .iRSTn       (iRSTn),
    .iStart      (iStart),
    .iNumFrames  (iNumFrames),
    .iXValid     (iXValid),
    .iXData      (iXData),
    .oXReady     (oXReady),
    .iWValid     (iWValid),
    .iWData      (iWData),
    .oWReady     (oWReady),
    .oConvValid  (oConvValid),
    .oConvWren   (oConvWren),
    .oConvAddr   (oConvAddr),
    .oConvX      (oConvX),
    .oConvW      (oConvW),
    .iConvYValid (iConvYValid),
    .oYCount     (oYCount),
    .oFrameIdx   (oFrameIdx),
    .oBusy       (oBusy),
    .oDone       (oDone)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Job model: cycle numbers of the accepted start and of the DONE cycle,
  // accepts so far, accepts required, expected result count.
  int cyc = 0;
  int m_start = -10;
  int m_done_at = -5;
  int m_acc = 0;
  int m_total = 0;
  int m_y = 0;
  logic       e_valid = 1'b0, e_wren = 1'b0;
  logic [4:0] e_addr = '0;
  logic [7:0] e_x = '0, e_w = '0;

  int   kx_pct = 100, kw_pct = 100, ky_mode = 0, noise = 0;
  bit   start_req = 1'b0;
  logic [7:0] start_nf = 8'd0;
  int   v_obs = 0, w_obs = 0, y_seen = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_start = -10; m_done_at = -5; m_acc = 0; m_total = 0; m_y = 0;
    e_valid = 1'b0; e_wren = 1'b0; e_addr = '0; e_x = '0; e_w = '0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step();
    int p;
    bit need_w, streaming, exp_xr, exp_wr, acc, busy_now;
    busy_now   = (cyc > m_start) && (cyc <= m_done_at);
    iXValid    = ($urandom_range(99) < kx_pct);
    iWValid    = ($urandom_range(99) < kw_pct);
    iXData     = 8'($urandom);
    iWData     = 8'($urandom);
    iStart     = start_req || (noise != 0 && busy_now && $urandom_range(99) < 3);
    iNumFrames = start_req ? start_nf : 8'($urandom);
    start_req  = 1'b0;
    if (ky_mode == 1) begin
      iConvYValid = oConvValid && ((y_seen % PPF) < 784);
      if (oConvValid) y_seen++;
    end else begin
      iConvYValid = 1'($urandom);
    end

    @(negedge iCLK);
    p         = m_acc % PPF;
    streaming = (cyc > m_start) && (m_acc < m_total);
`ifdef CONV_SCHED_WREUSE_EN
    need_w    = (p < KK) && (m_acc / PPF == 0);
`else
    need_w    = (p < KK);
`endif
    exp_xr = streaming && (!need_w || iWValid);
    exp_wr = streaming && need_w && iXValid;
    chk("x_ready", oXReady, exp_xr);
    chk("w_ready", oWReady, exp_wr);
    chk("conv_valid", oConvValid, e_valid);
    chk("conv_wren", oConvWren, e_wren);
    chk("conv_addr", oConvAddr, e_addr);
    chk("conv_x", oConvX, e_x);
    chk("conv_w", oConvW, e_w);
    chk("done", oDone, (cyc == m_done_at));
    chk("busy", oBusy, busy_now);
    chk("y_count", oYCount, m_y);
    if (streaming) chk("frame_idx", oFrameIdx, m_acc / PPF);
    if (oDone && ky_mode == 1) chk("y_count_at_done", oYCount, 2352);
    if (oConvValid) v_obs++;
    if (iWValid && oWReady) w_obs++;

    acc     = exp_xr && iXValid;
    e_valid = acc;
    e_wren  = acc && need_w;
    e_addr  = (acc && need_w) ? 5'(p) : 5'd0;
    e_x     = acc ? iXData : 8'd0;
    e_w     = (acc && need_w) ? iWData : 8'd0;
    if (acc) begin
      m_acc++;
      // Last pixel output next cycle, then DRAIN_CYC cycles, then DONE.
      if (m_acc == m_total) m_done_at = cyc + 7;
    end
    if (cyc > m_start && cyc < m_done_at && iConvYValid && m_y < YSAT) m_y++;
    if (cyc > m_done_at && iStart) begin
      m_start   = cyc;
      m_total   = int'(iNumFrames) * PPF;
      m_acc     = 0;
      m_y       = 0;
      m_done_at = (iNumFrames == 8'd0) ? cyc + 1 : BIG;
    end
    cyc++;
    @(posedge iCLK);
    #1;
  endtask

  task automatic run_job(input int nf, input int xp, input int wp, input int ym, input int nz);
    int guard;
    int exp_w;
    kx_pct = xp; kw_pct = wp; ky_mode = ym; noise = nz;
    v_obs = 0; w_obs = 0; y_seen = 0;
    start_req = 1'b1;
    start_nf  = 8'(nf);
    step();
    guard = 0;
    while (cyc <= m_done_at && guard < 20000) begin
      step();
      guard++;
    end
    chk("job_in_budget", (guard < 20000), 1);
`ifdef CONV_SCHED_WREUSE_EN
    exp_w = (nf > 0) ? KK : 0;
`else
    exp_w = KK * nf;
`endif
    chk("conv_valid_total", v_obs, nf * PPF);
    chk("weight_accepts", w_obs, exp_w);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_xready"}, oXReady, 0);
    chk({tag, "_wready"}, oWReady, 0);
    chk({tag, "_valid"}, oConvValid, 0);
    chk({tag, "_wren"}, oConvWren, 0);
    chk({tag, "_addr"}, oConvAddr, 0);
    chk({tag, "_x"}, oConvX, 0);
    chk({tag, "_w"}, oConvW, 0);
    chk({tag, "_ycount"}, oYCount, 0);
    chk({tag, "_frame"}, oFrameIdx, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_done"}, oDone, 0);
  endtask

  initial begin
    iXValid = 1'b1; iWValid = 1'b1; iStart = 1'b1; iNumFrames = 8'd3;
    repeat (3) @(posedge iCLK);
    #1;
    check_all_zero("reset");
    iStart = 1'b0;
    iRSTn  = 1'b1;
    model_reset();

    run_job(1, 100, 100, 0, 0);   // single frame, both sources always valid
    run_job(0, 100, 100, 0, 0);   // empty job: DONE straight after start
    run_job(2, 70, 70, 0, 1);     // random bubbles, stray starts while busy
    run_job(6, 100, 100, 0, 0);   // six frames back to back

    // Abort a job mid-stream with an asynchronous reset between edges.
    kx_pct = 80; kw_pct = 80; ky_mode = 0; noise = 0;
    start_req = 1'b1; start_nf = 8'd4;
    repeat (1500) step();
    chk("abort_busy_before", oBusy, 1);
    #2;
    iRSTn = 1'b0;
    #1;
    check_all_zero("abort");
    model_reset();
    @(posedge iCLK);
    #1;
    iRSTn = 1'b1;
    cyc++;

    run_job(3, 100, 100, 1, 0);   // 784 results per frame
    run_job(1, 60, 60, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_conv_frame_scheduler
`default_nettype wire
